// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared processor constants and fetch state encoding
package cpu_pkg;

    localparam int PC_W      = 13;
    localparam int INSTR_W   = 16;
    localparam int MEM_DEPTH = 24;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, output register, valid/ready to decode
module fetch_unit #(
    parameter int PC_W      = cpu_pkg::PC_W,
    parameter int INSTR_W   = cpu_pkg::INSTR_W,
    parameter int MEM_DEPTH = cpu_pkg::MEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               done,
    output logic [15:0]        fetch_count
);
    import cpu_pkg::*;

    localparam logic [PC_W-1:0] END_PC = PC_W'(MEM_DEPTH);

    fetch_state_t    state;
    logic            transfer;
    logic            capture;
    logic [PC_W-1:0] pc_next;

    assign transfer = out_valid && out_ready;
    assign capture  = (state == FETCH_RUN) && (!out_valid || out_ready);
    assign pc_next  = pc + PC_W'(1);
    assign done     = (state == FETCH_DONE) && !out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH_IDLE;
            pc          <= '0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            fetch_count <= '0;
        end else begin
            if (transfer) begin
                fetch_count <= fetch_count + 16'd1;
            end

            // Redirect outranks capture; a transfer on the same edge is still counted above.
            if (state == FETCH_IDLE) begin
                if (start) begin
                    state <= FETCH_RUN;
                end
            end else if (redirect_valid) begin
                pc        <= redirect_target;
                out_valid <= 1'b0;
                state     <= (redirect_target < END_PC) ? FETCH_RUN : FETCH_DONE;
            end else if (capture) begin
                out_instr <= instruction;
                out_pc    <= pc;
                out_valid <= 1'b1;
                pc        <= pc_next;
                if (pc_next == END_PC) begin
                    state <= FETCH_DONE;
                end
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with delivery scoreboard
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] pc;
    logic [15:0] instruction;
    logic        redirect_valid;
    logic [12:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [12:0] out_pc;
    logic        done;
    logic [15:0] fetch_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    logic [15:0] model_count = 16'd0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .done           (done),
        .fetch_count    (fetch_count)
    );

    function automatic logic [15:0] mem_word(input logic [12:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (a < 13'd24) ? (16'hA000 ^ {lo, lo}) : 16'hFFFF;
    endfunction

    assign instruction = mem_word(pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, input int expect_cycles, input string name);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        check(name, n, expect_cycles);
    endtask

    task automatic run_until_out_pc(input logic [12:0] target, input int max,
                                    input int expect_cycles, input string name);
        int n;
        n = 0;
        while (!(out_valid && out_pc == target) && n < max) begin
            tick();
            n++;
        end
        check(name, n, expect_cycles);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_fetch_count"}, fetch_count, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Scoreboard: every transfer must be the next expected address with its memory word.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("fetch_count_model", fetch_count, model_count);
            if (out_valid) begin
                check("instr_matches_mem", out_instr, mem_word(out_pc));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery actual=%0d required=none", out_pc);
                end else begin
                    check("delivery_order", out_pc, exp_q.pop_front());
                end
                model_count = model_count + 16'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b0;
        #2  rst = 1'b0;
        #10 rst = 1'b1;
        tick();
        check_reset_values("reset");
        tick();
        tick();
        check("idle_no_fetch", out_valid, 0);

        // Full 24-word run with decode always ready.
        for (int a = 0; a < 24; a++) exp_q.push_back(a);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("start_no_capture_yet", out_valid, 0);
        tick();
        check("first_out_pc", out_pc, 0);
        check("first_out_instr", out_instr, 16'hA000);
        check("first_pc_advanced", pc, 1);
        wait_done(40, 24, "done_latency");
        check("full_run_count", fetch_count, 24);
        check("full_run_pc_stops", pc, 24);
        check("full_run_queue_empty", exp_q.size(), 0);

        // Restart at 0 via redirect from DONE, then stall holding pc 4.
        for (int a = 0; a < 9; a++) exp_q.push_back(a);
        redirect_valid  = 1'b1;
        redirect_target = 13'd0;
        tick();
        redirect_valid = 1'b0;
        check("redir0_from_done_flush", out_valid, 0);
        run_until_out_pc(13'd4, 10, 5, "reach_pc4");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_out_pc", out_pc, 4);
            check("stall_pc", pc, 5);
            check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        run_until_out_pc(13'd9, 10, 5, "reach_pc9");
        out_ready = 1'b0;
        tick();
        check("hold_pc9", out_pc, 9);

        // Redirect to 13 flushes held pc 9 without counting it.
        for (int a = 13; a < 16; a++) exp_q.push_back(a);
        for (int a = 20; a < 24; a++) exp_q.push_back(a);
        redirect_valid  = 1'b1;
        redirect_target = 13'd13;
        tick();
        redirect_valid = 1'b0;
        check("redir13_flush", out_valid, 0);
        check("redir13_pc", pc, 13);
        check("redir13_count", fetch_count, 33);
        out_ready = 1'b1;
        tick();
        check("redir13_out_pc", out_pc, 13);
        check("redir13_out_instr", out_instr, 16'hAD0D);
        tick();
        tick();
        check("before_simul_out_pc", out_pc, 15);

        // Redirect on the same edge as the transfer of pc 15.
        redirect_valid  = 1'b1;
        redirect_target = 13'd20;
        tick();
        redirect_valid = 1'b0;
        check("simul_count", fetch_count, 36);
        check("simul_flush", out_valid, 0);
        check("simul_pc", pc, 20);
        tick();
        check("simul_next_out_pc", out_pc, 20);
        wait_done(10, 4, "done_after_simul");
        check("second_run_count", fetch_count, 40);

        // Out-of-range redirect from RUN, then resume at 2.
        exp_q.push_back(2);
        out_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 13'd0;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("held_pc0", out_valid, 1);
        redirect_valid  = 1'b1;
        redirect_target = 13'd24;
        tick();
        redirect_valid = 1'b0;
        check("oor_flush", out_valid, 0);
        check("oor_done", done, 1);
        check("oor_pc", pc, 24);
        tick();
        check("oor_no_capture", out_valid, 0);
        check("oor_pc_no_wrap", pc, 24);
        check("oor_count", fetch_count, 40);
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 13'd2;
        tick();
        redirect_valid = 1'b0;
        check("resume_done_low", done, 0);
        tick();
        check("resume_out_pc", out_pc, 2);
        tick();
        check("resume_next_out_pc", out_pc, 3);
        check("resume_count", fetch_count, 41);

        // Asynchronous reset between edges while pc 3 is held.
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        model_count = 16'd0;
        #10 rst = 1'b1;
        tick();
        tick();
        tick();
        check("post_reset_idle_valid", out_valid, 0);
        check("post_reset_idle_pc", pc, 0);

        for (int a = 0; a < 3; a++) exp_q.push_back(a);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        check("restart_out_pc", out_pc, 3);
        check("restart_count", fetch_count, 3);
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
